// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        DB_LOW,
        DB_CHK_HI,
        DB_HIGH,
        DB_CHK_LO
    } db_state_t;

    localparam int TCNT_W = 32;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: a four-state FSM that accepts a level change only after
// STABLE_TICKS consecutive tick samples at the new level.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sync_in,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int SCNT_W = $clog2(STABLE_TICKS + 1);

    if (STABLE_TICKS < 1) begin : g_bad_param
        $error("debounce_chan: STABLE_TICKS must be at least 1");
    end

    db_state_t         state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [SCNT_W-1:0] scnt_inc;
    logic              db_q, rise_q, fall_q;

    assign scnt_inc = scnt_q + 1'b1;

    // A reversal of sync_in aborts the check before any tick is counted.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            DB_LOW: begin
                if (sync_in) begin
                    state_d = DB_CHK_HI;
                    scnt_d  = '0;
                end
            end
            DB_CHK_HI: begin
                if (!sync_in) begin
                    state_d = DB_LOW;
                end else if (tick) begin
                    scnt_d = scnt_inc;
                    if (scnt_inc == SCNT_W'(STABLE_TICKS)) begin
                        state_d = DB_HIGH;
                    end
                end
            end
            DB_HIGH: begin
                if (!sync_in) begin
                    state_d = DB_CHK_LO;
                    scnt_d  = '0;
                end
            end
            DB_CHK_LO: begin
                if (sync_in) begin
                    state_d = DB_HIGH;
                end else if (tick) begin
                    scnt_d = scnt_inc;
                    if (scnt_inc == SCNT_W'(STABLE_TICKS)) begin
                        state_d = DB_LOW;
                    end
                end
            end
            default: begin
                state_d = DB_LOW;
                scnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DB_LOW;
            scnt_q  <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            db_q    <= (state_d == DB_HIGH) || (state_d == DB_CHK_LO);
            rise_q  <= (state_q == DB_CHK_HI) && (state_d == DB_HIGH);
            fall_q  <= (state_q == DB_CHK_LO) && (state_d == DB_LOW);
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/debounce_ctrl.sv
// Multi-channel debounce controller: per-bit two-flop synchronizers, one shared
// free-running tick counter, and one debounce_chan per input.
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int  N_BTN        = 4,
    parameter int  CLK_FREQ     = 100_000_000,
    parameter real TICK_PERIOD  = 0.001,
    parameter int  STABLE_TICKS = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic             tick
);

    localparam int TICK_MAX = $rtoi(TICK_PERIOD * CLK_FREQ) - 1;

    if ((TICK_MAX < 1) || (STABLE_TICKS < 1)) begin : g_bad_param
        $error("debounce_ctrl: TICK_MAX and STABLE_TICKS must both be at least 1");
    end

    logic [N_BTN-1:0]  sync1_q, sync2_q;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              tick_w;

    assign tick_w = (tcnt_q == TCNT_W'(TICK_MAX));
    assign tcnt_d = tick_w ? '0 : tcnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            tcnt_q  <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            tcnt_q  <= tcnt_d;
        end
    end

    assign tick = tick_w;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick_w),
            .sync_in(sync2_q[gi]),
            .db_o   (btn_db[gi]),
            .rise_o (btn_rise[gi]),
            .fall_o (btn_fall[gi])
        );
    end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Self-checking bench for debounce_ctrl: directed scenarios followed by random
// bouncing inputs, all compared every cycle against a behavioural model.
module tb_debounce_ctrl;

    localparam int N     = 4;
    localparam int S     = 3;    // STABLE_TICKS
    localparam int TPER  = 10;   // TICK_MAX + 1 with CLK_FREQ=1000, TICK_PERIOD=0.01

    logic         clk;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_db;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;
    logic         tick;

    int n_checks;
    int n_errors;

    debounce_ctrl #(
        .N_BTN       (N),
        .CLK_FREQ    (1000),
        .TICK_PERIOD (0.01),
        .STABLE_TICKS(S)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_in  (btn_in),
        .btn_db  (btn_db),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: inputs are seen two cycles late; a change is accepted
    // once S ticks have occurred after the cycle in which the new level was
    // first seen, provided the level never reverted in between.
    logic [N-1:0] m_s1, m_s2;
    logic [N-1:0] m_db, m_rise, m_fall;
    int           m_cyc;
    int           m_ticks;
    bit           m_pend [N];
    int           m_base [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic [N-1:0] b, input logic r);
        bit tick_pre;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
            m_cyc = 0; m_ticks = 0;
            for (int c = 0; c < N; c++) begin
                m_pend[c] = 1'b0;
                m_base[c] = 0;
            end
        end else begin
            tick_pre = ((m_cyc % TPER) == TPER - 1);
            if (tick_pre) m_ticks++;
            for (int c = 0; c < N; c++) begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (m_s2[c] != m_db[c]) begin
                    if (!m_pend[c]) begin
                        m_pend[c] = 1'b1;
                        m_base[c] = m_ticks;
                    end else if (m_ticks - m_base[c] >= S) begin
                        m_db[c]   = m_s2[c];
                        m_rise[c] = m_s2[c];
                        m_fall[c] = !m_s2[c];
                        m_pend[c] = 1'b0;
                    end
                end else begin
                    m_pend[c] = 1'b0;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
            m_cyc++;
        end
    endtask

    task automatic step(input logic [N-1:0] b, input logic r);
        btn_in = b;
        reset  = r;
        @(posedge clk);
        model_update(b, r);
        @(negedge clk);
        check("db",   btn_db,   m_db);
        check("rise", btn_rise, m_rise);
        check("fall", btn_fall, m_fall);
        check("tick", tick, (m_cyc % TPER) == TPER - 1);
    endtask

    // Holds b for 45 cycles; reports the edge count at which channel ch first
    // reaches level pol and how many matching edge pulses were seen.
    task automatic measure(input int ch, input logic [N-1:0] b, input logic pol,
                           output int lat, output int pulses);
        lat = -1;
        pulses = 0;
        for (int k = 1; k <= 45; k++) begin
            step(b, 1'b0);
            if (pol ? btn_rise[ch] : btn_fall[ch]) pulses++;
            if (lat < 0 && btn_db[ch] == pol) lat = k;
        end
    endtask

    initial begin
        int lat, pulses, first_tick, act, r2c, r3c, r2t, r3t, pre;
        logic [N-1:0] lvl;
        bit bouncy;
        n_checks = 0;
        n_errors = 0;
        btn_in = '1;
        reset  = 1'b1;

        // 1: reset with all buttons held
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1'b1);
            check("rst_outs", {btn_db, btn_rise, btn_fall}, '0);
        end
        first_tick = -1;
        for (int k = 1; k <= 12; k++) begin
            step(4'b0000, 1'b0);
            if (k == 1) check("post_rst_outs", {btn_db, btn_rise, btn_fall}, '0);
            if (first_tick < 0 && tick) first_tick = k + 1;
        end
        check("first_tick_cycle", first_tick, 10);
        $display("scenario reset: first tick in cycle %0d", first_tick);

        // 2: clean press on channel 0
        measure(0, 4'b0001, 1'b1, lat, pulses);
        check("press_lat_in_window", (lat >= 23 && lat <= 33), 1'b1);
        check("press_rise_count", pulses, 1);
        $display("scenario press: btn_db[0] rose %0d edges after change", lat);

        // 3: bounce on channel 1 while channel 0 stays held
        act = 0;
        lvl = 4'b0001;
        for (int k = 0; k < 80; k++) begin
            if (k < 40 && (k % 5) == 0) lvl[1] = ~lvl[1];
            if (k >= 40) lvl[1] = 1'b0;
            step(lvl, 1'b0);
            if (btn_db[1] || btn_rise[1] || btn_fall[1]) act++;
        end
        check("bounce_no_activity", act, 0);
        $display("scenario bounce: channel 1 active cycles %0d", act);

        // 4: release channel 0
        measure(0, 4'b0000, 1'b0, lat, pulses);
        check("release_lat_in_window", (lat >= 23 && lat <= 33), 1'b1);
        check("release_fall_count", pulses, 1);
        $display("scenario release: btn_db[0] fell %0d edges after change", lat);

        // 5: simultaneous press on channels 2 and 3
        r2c = 0; r3c = 0; r2t = -1; r3t = -2;
        for (int k = 1; k <= 45; k++) begin
            step(4'b1100, 1'b0);
            if (btn_rise[2]) begin r2c++; r2t = k; end
            if (btn_rise[3]) begin r3c++; r3t = k; end
        end
        check("simul_rise2_count", r2c, 1);
        check("simul_rise3_count", r3c, 1);
        check("simul_same_cycle", r2t, r3t);
        $display("scenario simultaneous: rise2 at %0d rise3 at %0d", r2t, r3t);
        for (int k = 0; k < 45; k++) step(4'b0000, 1'b0);

        // 6: reset in the middle of a check, button kept held
        pre = 0;
        for (int k = 1; k <= 14; k++) begin
            step(4'b0001, 1'b0);
            if (btn_rise[0]) pre++;
        end
        step(4'b0001, 1'b1);
        check("midrst_outs", {btn_db, btn_rise, btn_fall}, '0);
        measure(0, 4'b0001, 1'b1, lat, pulses);
        check("midrst_no_early_rise", pre, 0);
        check("midrst_lat_in_window", (lat >= 23 && lat <= 33), 1'b1);
        check("midrst_rise_count", pulses, 1);
        $display("scenario reset-mid-check: rise %0d edges after deassert", lat);

        // 7: random bouncing inputs with occasional resets
        lvl = 4'b0001;
        for (int seg = 0; seg < 50; seg++) begin
            bouncy = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 60; k++) begin
                for (int c = 0; c < N; c++) begin
                    if (bouncy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0))
                        lvl[c] = ~lvl[c];
                end
                step(lvl, ($urandom_range(0, 1499) == 0));
            end
            $display("random segment %0d bouncy=%0d db=%b", seg, bouncy, btn_db);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
